// File: rtl/sprite_scanline_renderer_pkg.sv
// Shared types and defaults for the sprite scanline renderer.
package sprite_scanline_renderer_pkg;

    localparam int unsigned HPOS_W           = 9;
    localparam int unsigned SPRITE_LOAD_HPOS = 257;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_LOAD   = 3'd1,
        S_FETCH_ADDR  = 3'd2,
        S_FETCH_DATA  = 3'd3,
        S_WAIT_HSTART = 3'd4,
        S_DRAW        = 3'd5
    } sprite_state_e;

endpackage

// File: rtl/sprite_scanline_renderer.sv
// Draws one monochrome bitmap sprite: fetches a ROM row during hblank and
// shifts it out as a 1-bit gfx stream starting one pixel after the latched X.
module sprite_scanline_renderer
    import sprite_scanline_renderer_pkg::*;
#(
    parameter int unsigned SPRITE_W  = 8,
    parameter int unsigned SPRITE_H  = 8,
    parameter int unsigned ROW_AW    = 3,
    parameter int unsigned LOAD_HPOS = SPRITE_LOAD_HPOS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HPOS_W-1:0]   hpos,
    input  logic [HPOS_W-1:0]   vpos,
    input  logic                display_on,
    input  logic [HPOS_W-1:0]   sprite_x,
    input  logic [HPOS_W-1:0]   sprite_y,
    output logic [ROW_AW-1:0]   rom_addr,
    input  logic [SPRITE_W-1:0] rom_bits,
    output logic                gfx,
    output logic                in_progress
);

    localparam int unsigned XCW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

    sprite_state_e       state_q, state_d;
    logic [ROW_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [ROW_AW-1:0]   ycount_q, ycount_d;
    logic [XCW-1:0]      xcount_q, xcount_d;
    logic [SPRITE_W-1:0] row_q, row_d;
    logic [HPOS_W-1:0]   x_q, x_d;
    logic                at_load;

    assign at_load = (hpos == HPOS_W'(LOAD_HPOS));

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        ycount_d   = ycount_q;
        xcount_d   = xcount_q;
        row_d      = row_q;
        x_d        = x_q;
        unique case (state_q)
            S_IDLE: begin
                if (at_load && (vpos == sprite_y)) begin
                    x_d        = sprite_x;
                    ycount_d   = '0;
                    rom_addr_d = '0;
                    state_d    = S_FETCH_ADDR;
                end
            end
            S_WAIT_LOAD: begin
                if (at_load) state_d = S_FETCH_ADDR;
            end
            S_FETCH_ADDR: begin
                rom_addr_d = ycount_q;
                state_d    = S_FETCH_DATA;
            end
            S_FETCH_DATA: begin
                row_d   = rom_bits;
                state_d = S_WAIT_HSTART;
            end
            S_WAIT_HSTART: begin
                if (hpos == x_q) begin
                    xcount_d = '0;
                    state_d  = S_DRAW;
                end else if (at_load) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAW: begin
                // Row is shifted MSB-first, so the MSB is always row[SPRITE_W-1-xcount].
                row_d    = row_q << 1;
                xcount_d = xcount_q + XCW'(1);
                if (xcount_q == XCW'(SPRITE_W - 1)) begin
                    if (ycount_q == ROW_AW'(SPRITE_H - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        // Address advances with ycount so the sync ROM output is
                        // already settled when FETCH_DATA captures it.
                        ycount_d   = ycount_q + ROW_AW'(1);
                        rom_addr_d = ycount_q + ROW_AW'(1);
                        state_d    = S_WAIT_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            ycount_q   <= '0;
            xcount_q   <= '0;
            row_q      <= '0;
            x_q        <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            ycount_q   <= ycount_d;
            xcount_q   <= xcount_d;
            row_q      <= row_d;
            x_q        <= x_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign gfx         = (state_q == S_DRAW) & row_q[SPRITE_W-1] & display_on;
    assign in_progress = (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_scanline_renderer.sv
// Scoreboard bench: the beam driver pushes expected pixels and state probes;
// a negedge monitor pops and compares them against gfx/in_progress/rom_addr.
module tb_sprite_scanline_renderer;

    localparam int H_MAX = 299;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic [8:0] hpos       = '0;
    logic [8:0] vpos       = '0;
    logic       display_on = 1'b0;
    logic [8:0] sprite_x   = 9'd20;
    logic [8:0] sprite_y   = 9'd10;
    logic [2:0] rom_addr;
    logic [7:0] rom_bits;
    logic       gfx;
    logic       in_progress;
    logic [7:0] rom_mem [8];

    typedef struct {
        int       key;
        logic     exp_ip;
        logic [2:0] exp_addr;
        bit       chk_addr;
        int       tag;
    } probe_t;

    int     pix_q[$];
    probe_t probe_q[$];
    int     cur_line = 0;
    int     line_ctr = 0;
    int     checks   = 0;
    int     failures = 0;
    bit     done     = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_bits <= rom_mem[rom_addr];

    sprite_scanline_renderer #(
        .SPRITE_W (8),
        .SPRITE_H (8),
        .ROW_AW   (3),
        .LOAD_HPOS(257)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .rom_addr   (rom_addr),
        .rom_bits   (rom_bits),
        .gfx        (gfx),
        .in_progress(in_progress)
    );

    task automatic run_line(input int v, input int rst_lo = -1, input int rst_hi = -1);
        for (int h = 0; h <= H_MAX; h++) begin
            @(posedge clk);
            #1;
            cur_line   = line_ctr;
            hpos       = 9'(h);
            vpos       = 9'(v);
            display_on = (h < 256) && (v < 240);
            reset      = (h >= rst_lo) && (h <= rst_hi);
        end
        line_ctr++;
    endtask

    // Expected pixels of one sprite row on the line about to be run.
    task automatic push_row(input int v, input int x, input logic [7:0] bits);
        for (int i = 0; i < 8; i++) begin
            if (bits[7-i] && (x + 1 + i) < 256 && v < 240)
                pix_q.push_back(line_ctr * 512 + x + 1 + i);
        end
    endtask

    task automatic probe(input int off, input int h, input logic ip,
                         input logic [2:0] addr, input bit chk, input int tag);
        probe_t p;
        p.key      = (line_ctr + off) * 512 + h;
        p.exp_ip   = ip;
        p.exp_addr = addr;
        p.chk_addr = chk;
        p.tag      = tag;
        probe_q.push_back(p);
    endtask

    task automatic sprite_lines(input int v0, input int v1, input int x, input int y);
        for (int v = v0; v <= v1; v++) begin
            if (v > y && v <= y + 8) push_row(v, x, rom_mem[3'(v - y - 1)]);
            run_line(v);
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) rom_mem[r] = 8'h00;

        probe(0, 5, 1'b0, 3'd0, 1'b1, 0);
        run_line(200, 0, 3);

        // Single row pattern 1000_0001 at x=20, y=10
        rom_mem[0] = 8'h81;
        sprite_x   = 9'd20;
        sprite_y   = 9'd10;
        probe(1, 257, 1'b0, 3'd0, 1'b0, 1);
        probe(1, 258, 1'b1, 3'd0, 1'b0, 2);
        probe(1, 260, 1'b1, 3'd0, 1'b1, 3);
        probe(2, 29, 1'b1, 3'd0, 1'b0, 4);
        probe(10, 258, 1'b0, 3'd0, 1'b0, 5);
        sprite_lines(9, 19, 20, 10);

        // Full solid sprite
        for (int r = 0; r < 8; r++) rom_mem[r] = 8'hFF;
        probe(4, 260, 1'b1, 3'd3, 1'b1, 6);
        probe(9, 28, 1'b1, 3'd0, 1'b0, 7);
        probe(9, 29, 1'b0, 3'd0, 1'b0, 8);
        probe(10, 258, 1'b0, 3'd0, 1'b0, 9);
        sprite_lines(9, 19, 20, 10);

        // Right edge: rows every other line, only 253..255 visible
        sprite_x = 9'd252;
        probe(3, 100, 1'b1, 3'd0, 1'b0, 10);
        probe(16, 260, 1'b1, 3'd0, 1'b0, 11);
        probe(16, 261, 1'b0, 3'd0, 1'b0, 12);
        probe(17, 258, 1'b0, 3'd0, 1'b0, 13);
        for (int v = 9; v <= 27; v++) begin
            if (v >= 11 && v <= 25 && (v % 2) == 1) push_row(v, 252, 8'hFF);
            run_line(v);
        end

        // Trigger on line 260, rows wrap into next frame
        sprite_x   = 9'd20;
        sprite_y   = 9'd260;
        rom_mem[0] = 8'h81; rom_mem[1] = 8'h42; rom_mem[2] = 8'h24; rom_mem[3] = 8'h18;
        rom_mem[4] = 8'hF0; rom_mem[5] = 8'h0F; rom_mem[6] = 8'hAA; rom_mem[7] = 8'h55;
        probe(2, 260, 1'b1, 3'd1, 1'b1, 14);
        probe(9, 28, 1'b1, 3'd0, 1'b0, 15);
        probe(9, 29, 1'b0, 3'd0, 1'b0, 16);
        probe(11, 258, 1'b0, 3'd0, 1'b0, 17);
        run_line(259);
        run_line(260);
        push_row(261, 20, rom_mem[0]);
        run_line(261);
        for (int v = 0; v <= 8; v++) begin
            if (v <= 6) push_row(v, 20, rom_mem[3'(v + 1)]);
            run_line(v);
        end

        // Moving sprite_x mid-sprite only affects the next frame
        for (int r = 0; r < 8; r++) rom_mem[r] = 8'hFF;
        sprite_y = 9'd10;
        probe(4, 100, 1'b1, 3'd0, 1'b0, 18);
        sprite_lines(9, 12, 20, 10);
        sprite_x = 9'd100;
        sprite_lines(13, 19, 20, 10);
        run_line(261);
        sprite_lines(0, 19, 100, 10);

        // Reset in the middle of a drawn row
        sprite_x = 9'd20;
        probe(14, 23, 1'b1, 3'd2, 1'b1, 19);
        probe(14, 25, 1'b0, 3'd0, 1'b1, 20);
        probe(15, 258, 1'b0, 3'd0, 1'b0, 21);
        run_line(261);
        sprite_lines(0, 12, 20, 10);
        push_row(13, 20, 8'hF0);
        run_line(13, 24, 24);
        run_line(14);
        run_line(15);
        probe(19, 29, 1'b0, 3'd0, 1'b0, 23);
        probe(20, 258, 1'b0, 3'd0, 1'b0, 22);
        run_line(261);
        sprite_lines(0, 19, 20, 10);

        @(posedge clk);
        #1;
        done = 1'b1;
    end

    initial begin
        int key;
        forever begin
            @(negedge clk);
            if (done) begin
                while (pix_q.size() > 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pix_never_seen line=%0d hpos=%0d got=none want=gfx1",
                             pix_q[0] / 512, pix_q[0] % 512);
                    void'(pix_q.pop_front());
                end
                while (probe_q.size() > 0) begin
                    checks++;
                    failures++;
                    $display("FAIL probe%0d_never_seen got=none want=sampled", probe_q[0].tag);
                    void'(probe_q.pop_front());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end

            key = cur_line * 512 + int'(hpos);

            while (pix_q.size() > 0 && pix_q[0] < key) begin
                checks++;
                failures++;
                $display("FAIL pix_missed line=%0d hpos=%0d got=none want=gfx1",
                         pix_q[0] / 512, pix_q[0] % 512);
                void'(pix_q.pop_front());
            end
            if (pix_q.size() > 0 && pix_q[0] == key) begin
                checks++;
                if (gfx !== 1'b1) begin
                    failures++;
                    $display("FAIL pix line=%0d hpos=%0d gfx got=%b want=1", cur_line, hpos, gfx);
                end
                void'(pix_q.pop_front());
            end else if (gfx !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL pix_extra line=%0d hpos=%0d gfx got=%b want=0", cur_line, hpos, gfx);
            end

            while (probe_q.size() > 0 && probe_q[0].key < key) begin
                checks++;
                failures++;
                $display("FAIL probe%0d_missed got=none want=sampled", probe_q[0].tag);
                void'(probe_q.pop_front());
            end
            if (probe_q.size() > 0 && probe_q[0].key == key) begin
                checks++;
                if (in_progress !== probe_q[0].exp_ip) begin
                    failures++;
                    $display("FAIL probe%0d_in_progress line=%0d hpos=%0d got=%b want=%b",
                             probe_q[0].tag, cur_line, hpos, in_progress, probe_q[0].exp_ip);
                end
                if (probe_q[0].chk_addr) begin
                    checks++;
                    if (rom_addr !== probe_q[0].exp_addr) begin
                        failures++;
                        $display("FAIL probe%0d_rom_addr line=%0d hpos=%0d got=%0d want=%0d",
                                 probe_q[0].tag, cur_line, hpos, rom_addr, probe_q[0].exp_addr);
                    end
                end
                void'(probe_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=no_finish want=finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
